beep_sequencer: RTL and testbench

- Consumes the four beep-rate toggle clocks from the rate clock generator and turns them into audible beeps on the buzzer pin plus a visible LED strobe.
- Selects one rate from a proximity/alert level, re-synchronises the selected toggle into the 50 MHz domain and detects its rising edge.
- Each detected edge fires one fixed-length tone burst; a continuous-tone mode covers the closest/alarm level.

---
 rtl/beep_sequencer_if.sv | 25 ++
 rtl/beep_sequencer.sv | 141 ++++++++++++++
 tb/tb_beep_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/beep_sequencer_if.sv
// Signal bundle between the alert controller side and the beep sequencer:
// rate selection, the four rate toggles, and the buzzer/LED/count outputs.
interface beep_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic [2:0]       rate_sel;
    logic             slower_clk;
    logic             slow_clk;
    logic             moderate_clk;
    logic             fast_clk;
    logic             buzzer;
    logic             beep_active;
    logic [CNT_W-1:0] beep_count;

    modport master (
        output enable, rate_sel, slower_clk, slow_clk, moderate_clk, fast_clk,
        input  buzzer, beep_active, beep_count
    );

    modport slave (
        input  enable, rate_sel, slower_clk, slow_clk, moderate_clk, fast_clk,
        output buzzer, beep_active, beep_count
    );
endinterface

// File: rtl/beep_sequencer.sv
// Beep sequencer: resynchronises the selected rate toggle and turns each rising
// edge into a fixed-length tone burst, or a continuous tone at the alarm level.
module beep_sequencer #(
    parameter int TONE_HALF   = 12500,
    parameter int BEEP_CYCLES = 1000000,
    parameter int CNT_W       = 8
) (
    input logic             clk,
    input logic             reset_n,
    beep_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BEEP = 2'd1;
    localparam logic [1:0] CONT = 2'd2;

    localparam int TONE_W  = $clog2(TONE_HALF + 1);
    localparam int BURST_W = $clog2(BEEP_CYCLES + 1);
    localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_HALF - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BEEP_CYCLES - 1);

    logic [1:0]         state;
    logic [3:0]         rate_in;
    logic [3:0]         sync1;
    logic [3:0]         sync2;
    logic [3:0]         hist;
    logic [3:0]         rise;
    logic               sel_rise;
    logic               rate_beep;
    logic               rate_cont;
    logic [TONE_W-1:0]  tone_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic               buzzer_q;
    logic               active_q;
    logic [CNT_W-1:0]   count_q;

    assign rate_in   = {bus.fast_clk, bus.moderate_clk, bus.slow_clk, bus.slower_clk};
    assign rise      = sync2 & ~hist;
    assign rate_beep = (bus.rate_sel >= 3'd1) && (bus.rate_sel <= 3'd4);
    assign rate_cont = (bus.rate_sel == 3'd5);

    // Edges are detected per input before the mux, so re-selecting never fakes one.
    always_comb begin
        sel_rise = 1'b0;
        case (bus.rate_sel)
            3'd1:    sel_rise = rise[0];
            3'd2:    sel_rise = rise[1];
            3'd3:    sel_rise = rise[2];
            3'd4:    sel_rise = rise[3];
            default: sel_rise = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= rate_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tone_cnt  <= '0;
            burst_cnt <= '0;
            buzzer_q  <= 1'b0;
            active_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state)
                BEEP: begin
                    if (!bus.enable || !(rate_beep || rate_cont)) begin
                        state     <= IDLE;
                        buzzer_q  <= 1'b0;
                        active_q  <= 1'b0;
                        tone_cnt  <= '0;
                        burst_cnt <= '0;
                    end else if (rate_cont) begin
                        state     <= CONT;
                        buzzer_q  <= 1'b1;
                        tone_cnt  <= '0;
                        burst_cnt <= '0;
                    end else if (burst_cnt == BURST_LAST) begin
                        state     <= IDLE;
                        buzzer_q  <= 1'b0;
                        active_q  <= 1'b0;
                        tone_cnt  <= '0;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (tone_cnt == TONE_LAST) begin
                            buzzer_q <= ~buzzer_q;
                            tone_cnt <= '0;
                        end else begin
                            tone_cnt <= tone_cnt + 1'b1;
                        end
                    end
                end
                CONT: begin
                    if (!bus.enable || !rate_cont) begin
                        state    <= IDLE;
                        buzzer_q <= 1'b0;
                        active_q <= 1'b0;
                        tone_cnt <= '0;
                    end else if (tone_cnt == TONE_LAST) begin
                        buzzer_q <= ~buzzer_q;
                        tone_cnt <= '0;
                    end else begin
                        tone_cnt <= tone_cnt + 1'b1;
                    end
                end
                default: begin
                    tone_cnt  <= '0;
                    burst_cnt <= '0;
                    if (bus.enable && rate_beep && sel_rise) begin
                        state    <= BEEP;
                        buzzer_q <= 1'b1;
                        active_q <= 1'b1;
                        count_q  <= count_q + 1'b1;
                    end else if (bus.enable && rate_cont) begin
                        state    <= CONT;
                        buzzer_q <= 1'b1;
                        active_q <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        buzzer_q <= 1'b0;
                        active_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.buzzer      = buzzer_q;
    assign bus.beep_active = active_q;
    assign bus.beep_count  = count_q;
endmodule

// File: tb/tb_beep_sequencer.sv
// Bench for beep_sequencer: directed scenarios plus random stimulus, all checked
// cycle by cycle against a behavioural model built on time-since-entry.
module tb_beep_sequencer;
    localparam int TH = 4;
    localparam int BC = 20;
    localparam int CW = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    beep_sequencer_if #(.CNT_W(CW)) bif ();

    beep_sequencer #(
        .TONE_HALF  (TH),
        .BEEP_CYCLES(BC),
        .CNT_W      (CW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bif.slave)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = silent, 1 = burst, 2 = continuous; m_t = cycles since entry.
    int         m_mode  = 0;
    int         m_t     = 0;
    int         m_count = 0;
    logic [3:0] samp1 = '0, samp2 = '0, samp3 = '0;
    int         rises    = 0;
    logic       prev_act = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_count = 0;
        samp1 = '0; samp2 = '0; samp3 = '0;
        prev_act = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] rise;
        int  sel;
        bit  en;
        // An input change becomes visible to the decision two samples later.
        rise = samp2 & ~samp3;
        sel  = int'(bif.rate_sel);
        en   = bif.enable;
        case (m_mode)
            0: begin
                if (en && sel >= 1 && sel <= 4 && rise[sel-1]) begin
                    m_mode = 1; m_t = 0; m_count = (m_count + 1) % (1 << CW);
                end else if (en && sel == 5) begin
                    m_mode = 2; m_t = 0;
                end
            end
            1: begin
                if (!en || sel == 0 || sel > 5) m_mode = 0;
                else if (sel == 5) begin m_mode = 2; m_t = 0; end
                else if (m_t == BC - 1) m_mode = 0;
                else m_t++;
            end
            default: begin
                if (!en || sel != 5) m_mode = 0;
                else m_t++;
            end
        endcase
        samp3 = samp2;
        samp2 = samp1;
        samp1 = {bif.fast_clk, bif.moderate_clk, bif.slow_clk, bif.slower_clk};
    endtask

    task automatic tick();
        int exp_act, exp_buz;
        @(posedge clk);
        model_edge();
        #1;
        exp_act = (m_mode != 0) ? 1 : 0;
        exp_buz = (m_mode != 0 && ((m_t / TH) % 2 == 0)) ? 1 : 0;
        check("beep_active", 32'(bif.beep_active), 32'(exp_act));
        check("buzzer", 32'(bif.buzzer), 32'(exp_buz));
        check("beep_count", 32'(bif.beep_count), 32'(m_count));
        if (bif.beep_active && !prev_act) rises++;
        prev_act = bif.beep_active;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #2;
        check("rst_active", 32'(bif.beep_active), 32'd0);
        check("rst_buzzer", 32'(bif.buzzer), 32'd0);
        check("rst_count", 32'(bif.beep_count), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic [19:0] pattern;
        int n_active, lat, highs, r0;

        bif.enable = 1'b0; bif.rate_sel = 3'd0;
        bif.slower_clk = 1'b0; bif.slow_clk = 1'b0;
        bif.moderate_clk = 1'b0; bif.fast_clk = 1'b0;
        #1;
        apply_reset();

        // Single slow beep: latency, length, tone pattern
        bif.rate_sel = 3'd1; bif.enable = 1'b1;
        repeat (3) tick();
        bif.slower_clk = 1'b1;
        pattern = '0; n_active = 0; lat = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bif.beep_active) begin
                pattern = {pattern[18:0], bif.buzzer};
                n_active++;
                if (lat < 0) lat = i + 1;
            end
        end
        check("s1_latency", 32'(lat), 32'd3);
        check("s1_length", 32'(n_active), 32'd20);
        check("s1_pattern", 32'(pattern), 32'h000F0F0F);
        check("s1_count", 32'(bif.beep_count), 32'd1);
        check("s1_buzz_after", 32'(bif.buzzer), 32'd0);

        // Fast rate selected, slower toggling alongside is ignored
        bif.rate_sel = 3'd4; r0 = rises;
        for (int i = 0; i < 100; i++) begin
            if (i == 0 || i == 30 || i == 60) bif.fast_clk = ~bif.fast_clk;
            if (i % 7 == 0) bif.slower_clk = ~bif.slower_clk;
            tick();
        end
        check("s2_bursts", 32'(rises - r0), 32'd2);
        check("s2_count", 32'(bif.beep_count), 32'd3);

        // Second edge mid-burst is dropped
        r0 = rises;
        for (int i = 0; i < 50; i++) begin
            if (i == 0 || i == 15) bif.fast_clk = 1'b0;
            if (i == 5 || i == 16) bif.fast_clk = 1'b1;
            tick();
        end
        check("s3_bursts", 32'(rises - r0), 32'd1);
        check("s3_count", 32'(bif.beep_count), 32'd4);

        // Continuous tone then off
        bif.rate_sel = 3'd5; n_active = 0; highs = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bif.beep_active) n_active++;
            if (bif.buzzer) highs++;
        end
        check("s4_active", 32'(n_active), 32'd50);
        check("s4_highs", 32'(highs), 32'd26);
        bif.rate_sel = 3'd0;
        tick();
        check("s4_off_active", 32'(bif.beep_active), 32'd0);
        check("s4_off_buzzer", 32'(bif.buzzer), 32'd0);
        check("s4_count", 32'(bif.beep_count), 32'd4);

        // Enable dropped 7 cycles into a burst
        bif.rate_sel = 3'd1; bif.slower_clk = 1'b0;
        repeat (3) tick();
        bif.slower_clk = 1'b1;
        repeat (9) tick();
        bif.enable = 1'b0;
        tick();
        check("s5_active", 32'(bif.beep_active), 32'd0);
        check("s5_buzzer", 32'(bif.buzzer), 32'd0);
        check("s5_count", 32'(bif.beep_count), 32'd5);

        // Asynchronous reset mid-burst
        bif.enable = 1'b1; bif.slower_clk = 1'b0;
        repeat (3) tick();
        bif.slower_clk = 1'b1;
        repeat (8) tick();
        check("s6_pre_active", 32'(bif.beep_active), 32'd1);
        bif.slower_clk = 1'b0;
        apply_reset();
        repeat (10) tick();

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) bif.slower_clk   = ~bif.slower_clk;
            if ($urandom_range(0, 11) == 0) bif.slow_clk     = ~bif.slow_clk;
            if ($urandom_range(0, 11) == 0) bif.moderate_clk = ~bif.moderate_clk;
            if ($urandom_range(0, 11) == 0) bif.fast_clk     = ~bif.fast_clk;
            if ($urandom_range(0, 39) == 0) bif.rate_sel = 3'($urandom_range(0, 7));
            if (bif.enable ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 7) == 0))
                bif.enable = ~bif.enable;
            tick();
        end

        // 256 bursts wrap the counter
        bif.enable = 1'b1; bif.rate_sel = 3'd1;
        bif.slower_clk = 1'b0; bif.slow_clk = 1'b0;
        bif.moderate_clk = 1'b0; bif.fast_clk = 1'b0;
        apply_reset();
        r0 = rises;
        for (int b = 0; b < 256; b++) begin
            bif.slower_clk = 1'b1;
            repeat (12) tick();
            bif.slower_clk = 1'b0;
            repeat (12) tick();
        end
        repeat (5) tick();
        check("s8_bursts", 32'(rises - r0), 32'd256);
        check("s8_wrap", 32'(bif.beep_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
